// File: rtl/cpu_spi_cache_pkg.sv
// Shared types and default geometry for the 6502-to-SPI-SRAM read cache.
package cpu_spi_cache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} cache_state_e;

  localparam int ADDR_W_DEF     = 24;
  localparam int LINES_DEF      = 16;
  localparam int LINE_BYTES_DEF = 4;

  localparam int OFFSET_W = $clog2(LINE_BYTES_DEF);
  localparam int INDEX_W  = $clog2(LINES_DEF);
  localparam int TAG_W    = ADDR_W_DEF - OFFSET_W - INDEX_W;

endpackage

// File: rtl/cpu_spi_cache_tags.sv
// Valid/tag array: hit compare, per-line invalidate/allocate and whole-array flush.
module cpu_spi_cache_tags
  import cpu_spi_cache_pkg::*;
#(
  parameter int N_LINES = LINES_DEF,
  parameter int IDX_W   = INDEX_W,
  parameter int TG_W    = TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] look_idx,
  input  logic [TG_W-1:0]  look_tag,
  output logic             hit,
  input  logic             flush_all,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [TG_W-1:0]  set_tag
);

  logic [N_LINES-1:0] valid;
  logic [TG_W-1:0]    tag_q [N_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush_all) begin
      valid <= '0;
    end else begin
      if (inv_en) valid[inv_idx] <= 1'b0;
      if (set_en) valid[set_idx] <= 1'b1;
    end
  end

  // Tags are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (set_en) tag_q[set_idx] <= set_tag;
  end

  assign hit = valid[look_idx] && (tag_q[look_idx] == look_tag);

endmodule

// File: rtl/cpu_spi_cache.sv
// Direct-mapped write-through read cache between the 6502 bus and the SPI SRAM master.
module cpu_spi_cache
  import cpu_spi_cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINES      = LINES_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_en,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_rdy,
  output logic [7:0]        cpu_rdata,
  input  logic              flush,
  output logic [ADDR_W-1:0] dn_addr,
  output logic              dn_en,
  output logic              dn_wr,
  output logic [7:0]        dn_wdata,
  input  logic              dn_rdy,
  input  logic [7:0]        dn_rdata
);

  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_W - OFF_BITS - IDX_BITS;
  localparam logic [OFF_BITS-1:0] LAST_BYTE = OFF_BITS'(LINE_BYTES - 1);

  logic [OFF_BITS-1:0] off;
  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;

  assign off = cpu_addr[OFF_BITS-1:0];
  assign idx = cpu_addr[OFF_BITS+IDX_BITS-1:OFF_BITS];
  assign tag = cpu_addr[ADDR_W-1:OFF_BITS+IDX_BITS];

  cache_state_e        state;
  logic [OFF_BITS-1:0] cnt;
  logic                flush_pend;
  logic                hit;
  logic                flush_now;
  logic                fill_last;
  logic [7:0]          data_q [LINES][LINE_BYTES];

  // A pending flush wins over any request on the first IDLE cycle.
  assign flush_now = (state == IDLE) && (flush || flush_pend);
  assign fill_last = (state == FILL) && dn_rdy && (cnt == LAST_BYTE);

  cpu_spi_cache_tags #(
    .N_LINES (LINES),
    .IDX_W   (IDX_BITS),
    .TG_W    (TAG_BITS)
  ) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .look_idx  (idx),
    .look_tag  (tag),
    .hit       (hit),
    .flush_all (flush_now),
    .inv_en    ((state == IDLE) && !flush_now && cpu_en && !cpu_wr && !hit),
    .inv_idx   (idx),
    .set_en    (fill_last),
    .set_idx   (idx),
    .set_tag   (tag)
  );

  always_comb begin
    cpu_rdy = 1'b0;
    case (state)
      IDLE:    cpu_rdy = cpu_en && !cpu_wr && hit && !flush_now;
      WRITE:   cpu_rdy = dn_rdy;
      default: cpu_rdy = 1'b0;
    endcase
  end

  assign cpu_rdata = hit ? data_q[idx][off] : 8'h00;

  always_ff @(posedge clk) begin
    if (state == FILL && dn_rdy)
      data_q[idx][cnt] <= dn_rdata;
    else if (state == WRITE && dn_rdy && hit)
      data_q[idx][off] <= cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      dn_en      <= 1'b0;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_now) begin
            flush_pend <= 1'b0;
          end else if (cpu_en && cpu_wr) begin
            state    <= WRITE;
            dn_en    <= 1'b1;
            dn_wr    <= 1'b1;
            dn_addr  <= cpu_addr;
            dn_wdata <= cpu_wdata;
          end else if (cpu_en && !hit) begin
            state   <= FILL;
            cnt     <= '0;
            dn_en   <= 1'b1;
            dn_wr   <= 1'b0;
            dn_addr <= {tag, idx, {OFF_BITS{1'b0}}};
          end
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (dn_rdy) begin
            cnt <= cnt + OFF_BITS'(1);
            if (cnt == LAST_BYTE) begin
              state <= IDLE;
              dn_en <= 1'b0;
            end else begin
              dn_addr <= {tag, idx, cnt + OFF_BITS'(1)};
            end
          end
        end
        WRITE: begin
          if (flush) flush_pend <= 1'b1;
          if (dn_rdy) begin
            state <= IDLE;
            dn_en <= 1'b0;
            dn_wr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
